// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM state encoding and AXI response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Turns single read/write commands into AXI4-Lite transactions and reports one response per command.
// Every output comes straight from a flop; a response-wait timeout reports SLVERR instead of hanging.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 255
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,

    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                        RSP_RESP,
    output logic                              RSP_TIMEOUT,

    output logic                              BUSY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int CNT_W      = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST_I = (C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    state_t state, state_next;
    logic   aw_done, w_done, aw_done_next, w_done_next;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                            write_q;
    logic [CNT_W-1:0]                tmo_cnt;

    logic cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d, busy_d;
    logic cmd_hs, aw_hs, w_hs, ar_hs, resp_hs, in_resp, timeout_hit;

    assign cmd_hs  = CMD_VALID && CMD_READY;
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign in_resp = (state == WR_RESP) || (state == RD_RESP);
    assign resp_hs = write_q ? (M_AXI_BVALID && M_AXI_BREADY) : (M_AXI_RVALID && M_AXI_RREADY);

    // Tmo_cnt holds the number of earlier cycles spent in this response state, so the
    // last permitted cycle is when it equals C_TIMEOUT_CYCLES-1.
    assign timeout_hit = (C_TIMEOUT_CYCLES != 0) && in_resp && (tmo_cnt == TMO_LAST);

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // Outputs are decoded from the next state and registered here, so they change in
    // the same edge as the state itself.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            CMD_READY     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            RSP_VALID     <= 1'b0;
            BUSY          <= 1'b0;
        end else begin
            state         <= state_next;
            aw_done       <= aw_done_next;
            w_done        <= w_done_next;
            CMD_READY     <= cmd_ready_d;
            M_AXI_AWVALID <= awvalid_d;
            M_AXI_WVALID  <= wvalid_d;
            M_AXI_BREADY  <= bready_d;
            M_AXI_ARVALID <= arvalid_d;
            M_AXI_RREADY  <= rready_d;
            RSP_VALID     <= rsp_valid_d;
            BUSY          <= busy_d;
        end
    end

    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_next   = CMD_WRITE ? WR_REQ : RD_REQ;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if (aw_done_next && w_done_next) state_next = WR_RESP;
            end
            RD_REQ: begin
                if (ar_hs) state_next = RD_RESP;
            end
            WR_RESP, RD_RESP: begin
                if (resp_hs || timeout_hit) state_next = RSP;
            end
            RSP: begin
                if (RSP_VALID && RSP_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // IDLE and RSP keep BREADY/RREADY high so stray beats left over from a timeout drain away.
    always_comb begin
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = (state_next != IDLE);
        case (state_next)
            IDLE: begin
                cmd_ready_d = 1'b1;
                bready_d    = 1'b1;
                rready_d    = 1'b1;
            end
            WR_REQ: begin
                awvalid_d = !aw_done_next;
                wvalid_d  = !w_done_next;
            end
            WR_RESP: bready_d  = 1'b1;
            RD_REQ:  arvalid_d = 1'b1;
            RD_RESP: rready_d  = 1'b1;
            RSP: begin
                rsp_valid_d = 1'b1;
                bready_d    = 1'b1;
                rready_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            tmo_cnt     <= '0;
            RSP_RDATA   <= '0;
            RSP_RESP    <= RESP_OKAY;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            if (state == IDLE && cmd_hs) begin
                addr_q  <= CMD_ADDR;
                wdata_q <= CMD_WDATA;
                wstrb_q <= CMD_WSTRB;
                write_q <= CMD_WRITE;
            end

            if (in_resp && state_next == state) tmo_cnt <= tmo_cnt + CNT_W'(1);
            else                                tmo_cnt <= '0;

            // A real response arriving on the timeout cycle is reported instead of the timeout.
            if (in_resp && state_next == RSP) begin
                if (resp_hs) begin
                    RSP_RESP    <= write_q ? M_AXI_BRESP : M_AXI_RRESP;
                    RSP_RDATA   <= write_q ? '0 : M_AXI_RDATA;
                    RSP_TIMEOUT <= 1'b0;
                end else begin
                    RSP_RESP    <= RESP_SLVERR;
                    RSP_RDATA   <= '0;
                    RSP_TIMEOUT <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: scenario tasks drive a hand-played AXI slave,
// and a scoreboard compares every response handshake against the expected queue.
module tb_axi_lite_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic ACLK = 1'b0;
    logic ARESETN;
    logic CMD_VALID, CMD_READY, CMD_WRITE;
    logic [AW-1:0] CMD_ADDR;
    logic [DW-1:0] CMD_WDATA;
    logic [DW/8-1:0] CMD_WSTRB;
    logic RSP_VALID, RSP_READY, RSP_TIMEOUT, BUSY;
    logic [DW-1:0] RSP_RDATA;
    logic [1:0] RSP_RESP;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_RESP(RSP_RESP), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    function automatic rsp_t mk_rsp(input logic [1:0] resp, input logic [31:0] rdata, input logic to);
        rsp_t r;
        r.resp = resp;
        r.rdata = rdata;
        r.timeout = to;
        return r;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = data;
        CMD_WSTRB = strb;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Handshake counters and the response scoreboard, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (M_AXI_AWVALID === 1'b1 && M_AXI_AWREADY === 1'b1) aw_cnt++;
        if (M_AXI_WVALID === 1'b1 && M_AXI_WREADY === 1'b1) w_cnt++;
        if (M_AXI_BVALID === 1'b1 && M_AXI_BREADY === 1'b1) b_cnt++;
        if (M_AXI_ARVALID === 1'b1 && M_AXI_ARREADY === 1'b1) ar_cnt++;
        if (M_AXI_RVALID === 1'b1 && M_AXI_RREADY === 1'b1) r_cnt++;
        if (RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_rsp: got resp=%b rdata=%h to=%b want none",
                         RSP_RESP, RSP_RDATA, RSP_TIMEOUT);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if ({RSP_RESP, RSP_RDATA, RSP_TIMEOUT} !== {e.resp, e.rdata, e.timeout}) begin
                    errors++;
                    $display("[TB] FAIL sb_rsp: got resp=%b rdata=%h to=%b want resp=%b rdata=%h to=%b",
                             RSP_RESP, RSP_RDATA, RSP_TIMEOUT, e.resp, e.rdata, e.timeout);
                end
            end
        end
    end

    task automatic test_reset();
        ARESETN = 1'b0;
        tick();
        tick();
        checks++;
        if ({CMD_READY, BUSY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
             M_AXI_RREADY, RSP_VALID, RSP_TIMEOUT} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000000", {CMD_READY, BUSY, M_AXI_AWVALID,
                     M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RSP_VALID, RSP_TIMEOUT});
        end
        checks++;
        if ({RSP_RESP, RSP_RDATA} !== 34'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got resp=%b rdata=%h want 0", RSP_RESP, RSP_RDATA);
        end
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({CMD_READY, M_AXI_BREADY, M_AXI_RREADY, BUSY} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want 1110",
                     {CMD_READY, M_AXI_BREADY, M_AXI_RREADY, BUSY});
        end
    endtask

    task automatic test_write_basic();
        int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        exp_q.push_back(mk_rsp(2'b00, 32'h0, 1'b0));
        send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, BUSY, CMD_READY} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL wr_basic_c1_ctrl: got %b want 1110",
                     {M_AXI_AWVALID, M_AXI_WVALID, BUSY, CMD_READY});
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT} !==
            {32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            errors++;
            $display("[TB] FAIL wr_basic_payload: got %h %h %h %b want 00000010 deadbeef f 000",
                     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT);
        end
        tick();
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, RSP_VALID} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL wr_basic_c2_ctrl: got %b want 0010",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, RSP_VALID});
        end
        tick();
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b00;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++;
        if ({RSP_VALID, aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {1'b1, 32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL wr_basic_hs: got rsp_valid=%b aw=%0d w=%0d b=%0d want 1 1 1 1",
                     RSP_VALID, aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        checks++;
        if ({CMD_READY, BUSY, RSP_VALID} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL wr_basic_idle: got %b want 100", {CMD_READY, BUSY, RSP_VALID});
        end
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
    endtask

    task automatic test_write_w_first();
        int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
        exp_q.push_back(mk_rsp(2'b10, 32'h0, 1'b0));
        send_cmd(1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 4'h3);
        M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_WREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_AWADDR} !== {3'b100, 32'h0000_0044}) begin
                errors++;
                $display("[TB] FAIL wr_wfirst_hold%0d: got %b addr=%h want 100 addr=00000044", i,
                         {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, M_AXI_AWADDR);
            end
            tick();
        end
        M_AXI_AWREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, aw_cnt - aw0, w_cnt - w0} !==
            {3'b001, 32'd1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL wr_wfirst_done: got %b aw=%0d w=%0d want 001 1 1",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, aw_cnt - aw0, w_cnt - w0);
        end
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b10;
        tick();
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        tick();
        checks++;
        if ({RSP_VALID, b_cnt - b0} !== {1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL wr_wfirst_b: got rsp_valid=%b b=%0d want 1 1", RSP_VALID, b_cnt - b0);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
    endtask

    task automatic test_read_hold();
        exp_q.push_back(mk_rsp(2'b00, 32'h1234_5678, 1'b0));
        send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, M_AXI_ARPROT} !== {2'b10, 32'h0000_0020, 3'b000}) begin
            errors++;
            $display("[TB] FAIL rd_ar_issue: got v=%b rr=%b addr=%h prot=%b want 1 0 00000020 000",
                     M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, M_AXI_ARPROT);
        end
        tick();
        checks++;
        if (M_AXI_ARVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_ar_held: got %b want 1", M_AXI_ARVALID);
        end
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        checks++;
        if ({M_AXI_ARVALID, M_AXI_RREADY} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rd_resp_state: got %b want 01", {M_AXI_ARVALID, M_AXI_RREADY});
        end
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'h1234_5678;
        M_AXI_RRESP  = 2'b00;
        tick();
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = 32'hFFFF_FFFF;
        M_AXI_RRESP  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({RSP_VALID, RSP_RESP, RSP_RDATA, RSP_TIMEOUT} !== {3'b100, 32'h1234_5678, 1'b0}) begin
                errors++;
                $display("[TB] FAIL rd_rsp_stable%0d: got v=%b resp=%b rdata=%h to=%b want 1 00 12345678 0",
                         i, RSP_VALID, RSP_RESP, RSP_RDATA, RSP_TIMEOUT);
            end
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        checks++;
        if ({CMD_READY, BUSY, RSP_VALID} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rd_idle: got %b want 100", {CMD_READY, BUSY, RSP_VALID});
        end
    endtask

    task automatic test_back_to_back();
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_ARREADY = 1'b1;
        exp_q.push_back(mk_rsp(2'b00, 32'h0, 1'b0));
        send_cmd(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF);
        tick();
        M_AXI_BVALID = 1'b1;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++;
        if (RSP_VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_wr_latency: got %b want 1", RSP_VALID);
        end
        RSP_READY = 1'b1;
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'h0000_0200;
        exp_q.push_back(mk_rsp(2'b10, 32'hCAFE_F00D, 1'b0));
        tick();
        RSP_READY = 1'b0;
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_cmd_ready: got %b want 1", CMD_READY);
        end
        tick();
        CMD_VALID = 1'b0;
        checks++;
        if ({M_AXI_ARVALID, M_AXI_ARADDR} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("[TB] FAIL b2b_ar: got v=%b addr=%h want 1 00000200", M_AXI_ARVALID, M_AXI_ARADDR);
        end
        tick();
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'hCAFE_F00D;
        M_AXI_RRESP  = 2'b10;
        tick();
        M_AXI_RVALID = 1'b0;
        checks++;
        if (RSP_VALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_rd_latency: got %b want 1", RSP_VALID);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_ARREADY = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        int b0;
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        exp_q.push_back(mk_rsp(2'b10, 32'h0, 1'b1));
        send_cmd(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
        tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        while (RSP_VALID !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("[TB] FAIL tmo_cycles: got %0d want %0d", n, TMO);
        end
        checks++;
        if ({RSP_VALID, RSP_RESP, RSP_TIMEOUT, RSP_RDATA} !== {1'b1, 2'b10, 1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL tmo_rsp: got v=%b resp=%b to=%b rdata=%h want 1 10 1 0",
                     RSP_VALID, RSP_RESP, RSP_TIMEOUT, RSP_RDATA);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        b0 = b_cnt;
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b00;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++;
        if (b_cnt - b0 != 1) begin
            errors++;
            $display("[TB] FAIL tmo_stray_accept: got %0d want 1", b_cnt - b0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({RSP_VALID, BUSY, RSP_RESP, RSP_TIMEOUT} !== 5'b00101) begin
                errors++;
                $display("[TB] FAIL tmo_stray_quiet%0d: got %b want 00101", i,
                         {RSP_VALID, BUSY, RSP_RESP, RSP_TIMEOUT});
            end
            tick();
        end
    endtask

    task automatic test_b_at_timeout();
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        exp_q.push_back(mk_rsp(2'b00, 32'h0, 1'b0));
        send_cmd(1'b1, 32'h0000_0034, 32'h0BAD_F00D, 4'hC);
        tick();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        repeat (TMO - 1) tick();
        checks++;
        if ({M_AXI_BREADY, RSP_VALID} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bto_last_wait: got %b want 10", {M_AXI_BREADY, RSP_VALID});
        end
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b00;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++;
        if ({RSP_VALID, RSP_RESP, RSP_TIMEOUT} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL bto_real_wins: got v=%b resp=%b to=%b want 1 00 0",
                     RSP_VALID, RSP_RESP, RSP_TIMEOUT);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        checks++;
        if ({M_AXI_ARVALID, BUSY} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rst_mid_pre: got %b want 11", {M_AXI_ARVALID, BUSY});
        end
        ARESETN = 1'b0;
        tick();
        checks++;
        if ({M_AXI_ARVALID, CMD_READY, BUSY, RSP_VALID} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rst_mid_in: got %b want 0000", {M_AXI_ARVALID, CMD_READY, BUSY, RSP_VALID});
        end
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({CMD_READY, BUSY} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rst_mid_release: got %b want 10", {CMD_READY, BUSY});
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({RSP_VALID, M_AXI_ARVALID, RSP_RESP, RSP_RDATA} !== 36'b0) begin
                errors++;
                $display("[TB] FAIL rst_mid_norsp%0d: got v=%b ar=%b resp=%b rdata=%h want 0", i,
                         RSP_VALID, M_AXI_ARVALID, RSP_RESP, RSP_RDATA);
            end
            tick();
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
        RSP_READY = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;

        test_reset();
        test_write_basic();
        test_write_w_first();
        test_read_hold();
        test_back_to_back();
        test_timeout();
        test_b_at_timeout();
        test_reset_mid_read();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
